// File: rtl/dff_arst_en.sv
// Load-enabled storage register with asynchronous active-low reset.
// Holds a full message word (e.g. command header plus data block) until the next enabled load.
module dff_arst_en #(
  parameter int                 width_p     = 1,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  // Reject degenerate widths at elaboration time
  if (width_p < 1) begin : g_width_check
    $error("dff_arst_en: width_p must be >= 1 (got %0d)", width_p);
  end

  logic [width_p-1:0] data_q;
  logic [width_p-1:0] data_d;

  // Next-state select; an unknown enable poisons the stored word in simulation
  always_comb begin
    data_d = data_q;
    case (en_i)
      1'b1:    data_d = data_i;
      1'b0:    data_d = data_q;
      default: data_d = 'x;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      data_q <= reset_val_p;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: tb/tb_dff_arst_en.sv
// Scoreboard bench for dff_arst_en: an 8-bit instance and a 600-bit instance share control.
// The driver pushes expected outputs; a monitor pops and compares on every falling clock edge.
module tb_dff_arst_en;

  localparam int unsigned NW = 8;
  localparam int unsigned WW = 600;
  localparam logic [NW-1:0] RV_N = 8'hA5;
  localparam logic [WW-1:0] RV_W = '0;

  typedef struct {
    logic [NW-1:0] n;
    logic [WW-1:0] w;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [NW-1:0] din_n;
  logic [WW-1:0] din_w;
  logic [NW-1:0] dout_n;
  logic [WW-1:0] dout_w;

  int checks = 0;
  int errors = 0;

  exp_t          sb_q[$];
  logic [NW-1:0] m_n;
  logic [WW-1:0] m_w;

  dff_arst_en #(.width_p(NW), .reset_val_p(RV_N)) u_dut_n (
    .clk_i  (clk),
    .reset_i(rst_n),
    .en_i   (en),
    .data_i (din_n),
    .data_o (dout_n)
  );

  dff_arst_en #(.width_p(WW), .reset_val_p(RV_W)) u_dut_w (
    .clk_i  (clk),
    .reset_i(rst_n),
    .en_i   (en),
    .data_i (din_w),
    .data_o (dout_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: apply the clock edge to the model, then drive new inputs just after it
  task automatic cyc(input logic r, input logic e, input logic [NW-1:0] dn,
                     input logic [WW-1:0] dw);
    exp_t x;
    @(posedge clk);
    if (!rst_n) begin
      m_n = RV_N;
      m_w = RV_W;
    end else if (en) begin
      m_n = din_n;
      m_w = din_w;
    end
    #1;
    rst_n = r;
    en    = e;
    din_n = dn;
    din_w = dw;
    if (!r) begin
      m_n = RV_N;
      m_w = RV_W;
    end
    x.n = m_n;
    x.w = m_w;
    sb_q.push_back(x);
  endtask

  function automatic logic [WW-1:0] rand_wide();
    logic [WW-1:0] v;
    for (int i = 0; i < WW; i += 32) v[i +: 32] = WW'($urandom) << 0 >> 0 == 0 ? 32'($urandom) : 32'($urandom);
    return v;
  endfunction

  // Monitor: mid-cycle sample of both registers against the oldest expectation
  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        checks++;
        if (dout_n !== x.n) begin
          errors++;
          $display("FAIL narrow_q t=%0t got=%h exp=%h", $time, dout_n, x.n);
        end
        checks++;
        if (dout_w !== x.w) begin
          errors++;
          $display("FAIL wide_q t=%0t got=%h exp=%h", $time, dout_w, x.w);
        end
      end
    end
  end

  initial begin : driver
    logic [WW-1:0] alt;
    logic [WW-1:0] ones;
    alt  = {75{8'hAA}};
    ones = '1;
    rst_n = 1'b0;
    en    = 1'b0;
    din_n = '0;
    din_w = '0;
    m_n   = RV_N;
    m_w   = RV_W;

    // In reset, then release and preload 0x3C
    cyc(1'b0, 1'b0, 8'h00, '0);
    cyc(1'b0, 1'b1, 8'h99, ones);
    cyc(1'b1, 1'b1, 8'h3C, rand_wide());
    cyc(1'b1, 1'b0, 8'h00, '0);
    // Async assertion mid-cycle while a load is requested
    cyc(1'b0, 1'b1, 8'hFF, ones);
    cyc(1'b0, 1'b1, 8'hFF, ones);
    // Release with enable low for three edges, then load 0x12
    repeat (3) cyc(1'b1, 1'b0, 8'hEE, ones);
    cyc(1'b1, 1'b1, 8'h12, rand_wide());
    // Hold with random data
    repeat (10) cyc(1'b1, 1'b0, 8'($urandom), rand_wide());
    // Streaming 1..4
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b1, 8'(i), WW'(i));
    // Wide word: load alternating, offer all-ones without enable, then reset
    cyc(1'b1, 1'b1, 8'h55, alt);
    repeat (3) cyc(1'b1, 1'b0, 8'hFF, ones);
    cyc(1'b0, 1'b0, 8'hFF, ones);
    cyc(1'b1, 1'b0, 8'hFF, ones);
    // Reset vs load collision with 0x77
    cyc(1'b1, 1'b1, 8'h3C, alt);
    cyc(1'b0, 1'b1, 8'h77, ones);
    cyc(1'b1, 1'b0, 8'h77, ones);
    cyc(1'b1, 1'b0, 8'h00, '0);
    // Randomized traffic with occasional reset pulses
    for (int i = 0; i < 300; i++)
      cyc(($urandom_range(0, 9) != 0), 1'($urandom), 8'($urandom), rand_wide());
    cyc(1'b1, 1'b0, 8'h00, '0);
    cyc(1'b1, 1'b0, 8'h00, '0);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff_arst_en.md
Name:
dff_arst_en

Overview:
- Parameterized-width storage register with load enable and asynchronous active-low reset.
- Captures a full message word (e.g. a BP memory command header plus data block) when its valid strobe is high, and holds it for downstream logic until the next load.
- Used as the command-holding (MSHR-style) register inside bus adaptors such as the BP-to-Wishbone convertor.

Parameters:
- width_p, default 1: number of stored bits. Legal range is width_p >= 1; elaboration must fail for width_p < 1.
- reset_val_p, default 0: value forced onto data_o during reset. It is width_p bits wide, zero-extended or truncated to width_p.

Ports:
- clk_i  input  1  single clock; all loads occur on its rising edge.
- reset_i  input  1  asynchronous reset, active-low (0 = in reset).
- en_i  input  1  load enable, active-high, sampled on rising clk_i.
- data_i  input  width_p  value to capture.
- data_o  output  width_p  registered stored value.

Behaviour:
- Storage: one width_p-bit register. data_o is driven directly by the register, with no combinational path from data_i or en_i to data_o.
- Reset assertion: when reset_i falls to 0, data_o becomes reset_val_p immediately, independent of clk_i.
- While reset_i = 0: data_o holds reset_val_p; en_i and data_i are ignored on every clock edge.
- Reset release: reset_i rising to 0->1 does not change data_o. The first possible load is the first rising clk_i edge on which reset_i = 1. Release is expected to be synchronized upstream; the block adds no internal synchronizer.
- Load: on a rising clk_i with reset_i = 1 and en_i = 1, data_o takes the data_i value present at that edge. The new value is visible after clock-to-q, so latency is 1 cycle.
- Hold: on a rising clk_i with reset_i = 1 and en_i = 0, data_o keeps its previous value indefinitely.
- Back-to-back loads: en_i held high for N edges captures data_i on every edge, so data_o follows data_i delayed by one cycle.
- Reset mid-operation: reset asserted between or at clock edges overrides any pending load. The value loaded before reset is lost; after release, data_o = reset_val_p until the next enabled edge.
- Reset and enable together: reset_i = 0 at the same edge as en_i = 1 means no load; reset wins.
- Width rules:
  - All width_p bits load and hold together; there is no partial or byte enable.
  - Bit i of data_o corresponds to bit i of data_i.
  - Wide widths (hundreds of bits, e.g. 512-bit block plus header) must be supported with no behavioural change.
- X handling (simulation): if en_i is X at an enabled edge while out of reset, the register goes to X.
- No other outputs and no status flags.

Test Plan:
- Async reset: width_p = 8, reset_val_p = 8'hA5, register preloaded with 8'h3C. Drop reset_i to 0 mid-cycle -> data_o = 8'hA5 before the next clk_i edge. Pulse en_i = 1 with data_i = 8'hFF while in reset -> data_o stays 8'hA5.
- Release: raise reset_i, keep en_i = 0 for 3 edges -> data_o = 8'hA5. Set en_i = 1, data_i = 8'h12 -> data_o = 8'h12 one edge later.
- Hold: after loading 8'h12, set en_i = 0 and toggle data_i randomly for 10 cycles -> data_o = 8'h12 throughout.
- Streaming: en_i = 1, data_i = 1, 2, 3, 4 on consecutive edges -> data_o = 1, 2, 3, 4, each lagging data_i by one cycle.
- Wide word: width_p = 600, load an alternating 0xAA.. pattern, then an all-ones word with en_i = 0 -> every bit still holds the alternating pattern. Then reset with reset_val_p = 0 -> all 600 bits read 0.
- Reset vs load collision: assert reset_i = 0 coincident with an en_i = 1 edge carrying 8'h77 -> data_o = reset_val_p, never 8'h77.
